// File: rtl/output_streamer.sv
// Captures a DIM x DIM matrix on start and drains it one element per valid/ready handshake.
// Optional build macro OUT_TRANSPOSE_EN switches emission from row-major to column-major order.
module output_streamer #(
   parameter int DATA_W = 16,
   parameter int DIM    = 4,
   parameter int IDX_W  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [DATA_W*DIM*DIM-1:0]  matrix_in,
   output logic                       busy,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [IDX_W-1:0]           out_index,
   output logic                       out_last,
   output logic                       done,
   output logic                       dbg_state
);

   localparam int NUM = DIM * DIM;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   buf_q [NUM];
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [IDX_W-1:0]    out_index_q, out_index_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                xfer;
   logic                at_last;
   logic [IDX_W-1:0]    nxt_index;

   // Maps emission index to buffer slot.
   function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] j);
`ifdef OUT_TRANSPOSE_EN
      int unsigned ji;
      ji = int'(j);
      return IDX_W'((ji % DIM) * DIM + ji / DIM);
`else
      return j;
`endif
   endfunction

   // Valid/ready: an element moves on any rising edge where out_valid and out_ready are both high;
   // while out_valid is high and out_ready low, out_data/out_index/out_last stay frozen.
   assign xfer      = out_valid_q & out_ready;
   assign at_last   = (out_index_q == IDX_W'(NUM - 1));
   assign nxt_index = out_index_q + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start)           state_d = S_STREAM;
         S_STREAM: if (xfer && at_last) state_d = S_IDLE;
         default:                       state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Element 0 maps to slot 0 in either order, so present it straight from the bus.
               out_data_d  = matrix_in[DATA_W-1:0];
               out_index_d = '0;
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
               busy_d      = 1'b1;
            end
         end
         S_STREAM: begin
            if (xfer) begin
               if (at_last) begin
                  out_data_d  = '0;
                  out_index_d = '0;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  out_data_d  = buf_q[slot_of(nxt_index)];
                  out_index_d = nxt_index;
                  out_last_d  = (nxt_index == IDX_W'(NUM - 1));
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_q  <= '0;
         out_index_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Capture buffer needs no reset: it is only read after a fresh capture.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && start) begin
         for (int k = 0; k < NUM; k++) buf_q[k] <= matrix_in[k*DATA_W +: DATA_W];
      end
   end

   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = (state_q == S_STREAM);

endmodule
